alu_share_arb: RTL and testbench

Two-port arbiter and sequencer that shares the single 32-bit ALU between the integer pipeline (port 0) and the multi-cycle/branch helper unit (port 1).

- Accepts one operation at a time over a valid/ready request handshake and registers the operands.
- Drives the ALU from those registers for one cycle, captures result, overflow and zero.
- Returns them over a valid/ready response handshake to the requester that issued it.
- Grants alternate round-robin; illegal opcodes are rejected with an error flag and never reach the ALU.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 15 +
 rtl/alu_share_arb.sv | 126 ++++++++++++
 tb/tb_alu_share_arb.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the ALU share arbiter.
package alu_pkg;

  localparam logic [4:0] ALU_AND     = 5'h00;
  localparam logic [4:0] ALU_OR      = 5'h01;
  localparam logic [4:0] ALU_ADD     = 5'h02;
  localparam logic [4:0] ALU_SUB     = 5'h03;
  localparam logic [4:0] ALU_XOR     = 5'h04;
  localparam logic [4:0] ALU_SLT     = 5'h05;
  localparam logic [4:0] ALU_SLTU    = 5'h06;
  localparam logic [4:0] ALU_SLL     = 5'h07;
  localparam logic [4:0] ALU_SRL     = 5'h08;
  localparam logic [4:0] ALU_SRA     = 5'h09;
  localparam logic [4:0] ALU_BGE     = 5'h0A;
  localparam logic [4:0] ALU_BGEU    = 5'h0B;
  localparam logic [4:0] ALU_OP_LAST = 5'h0B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port not served last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant from the valids and the previously served port
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
    else                grant = valid;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Sequencer sharing one ALU between the integer pipeline (port 0) and the helper unit (port 1).
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_res,
  output logic              rsp_ovf,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_ovf,
  input  logic              alu_zero
);

  state_t            state;
  logic              src;
  logic              last_grant;
  logic              ill_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [1:0]        grant;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_ill;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Accept handshake only in IDLE and only toward the granted port
  always_comb begin
    req0_ready = !rst && (state == IDLE) && grant[0];
    req1_ready = !rst && (state == IDLE) && grant[1];
  end

  // Select the granted request's payload and classify its opcode
  always_comb begin
    sel_op  = grant[1] ? req1_op : req0_op;
    sel_a   = grant[1] ? req1_a  : req0_a;
    sel_b   = grant[1] ? req1_b  : req0_b;
    sel_ill = sel_op > OP_W'(ALU_OP_LAST);
  end

  // ALU is driven purely from the operand registers
  always_comb begin
    alu_a  = a_q;
    alu_b  = b_q;
    alu_op = op_q;
  end

  // Sequencer: latch request, run ALU for one cycle, hold response until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      src        <= 1'b0;
      last_grant <= 1'b1;
      ill_q      <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_res    <= '0;
      rsp_ovf    <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            src   <= grant[1];
            ill_q <= sel_ill;
            op_q  <= sel_ill ? '0 : sel_op;
            a_q   <= sel_a;
            b_q   <= sel_b;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_res    <= ill_q ? '0 : alu_res;
          rsp_ovf    <= ill_q ? 1'b0 : alu_ovf;
          rsp_zero   <= ill_q ? 1'b0 : alu_zero;
          rsp_err    <= ill_q;
          rsp0_valid <= !src;
          rsp1_valid <= src;
          state      <= RESP;
        end
        RESP: begin
          if (src ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            last_grant <= src;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb with a behavioural ALU and a response scoreboard.
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OW-1:0] req0_op, req1_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp_res;
  logic          rsp_ovf, rsp_zero, rsp_err;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic [OW-1:0] alu_op;
  logic          alu_ovf, alu_zero;

  always #5 clk = ~clk;

  alu_share_arb #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_ovf(alu_ovf), .alu_zero(alu_zero)
  );

  // Behavioural ALU standing in for the shared datapath
  logic [DW-1:0] m_res;
  logic          m_ovf;
  always_comb begin
    m_res = '0;
    m_ovf = 1'b0;
    case (alu_op)
      ALU_AND:  m_res = alu_a & alu_b;
      ALU_OR:   m_res = alu_a | alu_b;
      ALU_ADD:  begin
        m_res = alu_a + alu_b;
        m_ovf = (alu_a[31] == alu_b[31]) && (m_res[31] != alu_a[31]);
      end
      ALU_SUB:  begin
        m_res = alu_a - alu_b;
        m_ovf = (alu_a[31] != alu_b[31]) && (m_res[31] != alu_a[31]);
      end
      ALU_XOR:  m_res = alu_a ^ alu_b;
      ALU_SLT:  m_res = 32'($signed(alu_a) < $signed(alu_b));
      ALU_SLTU: m_res = 32'(alu_a < alu_b);
      ALU_SLL:  m_res = alu_a << alu_b[4:0];
      ALU_SRL:  m_res = alu_a >> alu_b[4:0];
      ALU_SRA:  m_res = 32'($signed(alu_a) >>> alu_b[4:0]);
      ALU_BGE:  m_res = 32'($signed(alu_a) >= $signed(alu_b));
      ALU_BGEU: m_res = 32'(alu_a >= alu_b);
      default:  m_res = '0;
    endcase
  end
  assign alu_res  = m_res;
  assign alu_ovf  = m_ovf;
  assign alu_zero = (m_res == '0);

  typedef struct {
    logic          port;
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          ovf;
    logic          zero;
    logic          err;
  } vec_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  vec_t cur0, cur1, exec_v;
  vec_t pend_q[$];
  int   glog[$];
  logic hold0, hold1, exec_pending;
  int   acc_cyc0, acc_cyc1, hs_cyc0, hs_cyc1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // One clock: sample at negedge, score accepts/responses, then step past the rising edge
  task automatic tick();
    vec_t          e;
    logic          acc0, acc1;
    logic [OW-1:0] eop;
    @(negedge clk);
    cyc++;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if (rst) begin
      pend_q.delete();
      exec_pending = 1'b0;
    end else begin
      if (exec_pending) begin
        eop = (exec_v.op > ALU_OP_LAST) ? 5'h00 : exec_v.op;
        chk("exec_alu_op", 32'(alu_op), 32'(eop));
        chk("exec_alu_a", alu_a, exec_v.a);
        chk("exec_alu_b", alu_b, exec_v.b);
        exec_pending = 1'b0;
      end
      if (req0_ready || req1_ready) chk("single_ready", 32'(req0_ready && req1_ready), 32'(0));
      if (acc0) begin
        e = cur0; e.port = 1'b0;
        pend_q.push_back(e); glog.push_back(0);
        exec_v = e; exec_pending = 1'b1; acc_cyc0 = cyc;
      end
      if (acc1) begin
        e = cur1; e.port = 1'b1;
        pend_q.push_back(e); glog.push_back(1);
        exec_v = e; exec_pending = 1'b1; acc_cyc1 = cyc;
      end
      if (rsp0_valid || rsp1_valid) begin
        chk("rsp_onehot", 32'(rsp0_valid && rsp1_valid), 32'(0));
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
          if (rsp1_valid) hs_cyc1 = cyc; else hs_cyc0 = cyc;
          if (pend_q.size() == 0) fail_now("unexpected_response");
          else begin
            e = pend_q.pop_front();
            chk("rsp_port", 32'(rsp1_valid), 32'(e.port));
            chk("rsp_res",  rsp_res, e.res);
            chk("rsp_ovf",  32'(rsp_ovf),  32'(e.ovf));
            chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
            chk("rsp_err",  32'(rsp_err),  32'(e.err));
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (acc0 && !hold0) req0_valid = 1'b0;
    if (acc1 && !hold1) req1_valid = 1'b0;
  endtask

  // Run until all requests are served and all responses scored, within a cycle budget
  task automatic drain(input int budget);
    int n = 0;
    while ((pend_q.size() != 0 || req0_valid || req1_valid) && n < budget) begin
      tick();
      n++;
    end
    if (pend_q.size() != 0 || req0_valid || req1_valid) fail_now("drain_timeout");
  endtask

  task automatic present(input vec_t v);
    if (v.port) begin
      cur1 = v; req1_op = v.op; req1_a = v.a; req1_b = v.b; req1_valid = 1'b1;
    end else begin
      cur0 = v; req0_op = v.op; req0_a = v.a; req0_b = v.b; req0_valid = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    vec_t v0, v1;
    int   n;

    tbl[0]  = '{port:1'b0, op:ALU_ADD,  a:32'h7FFF_FFFF, b:32'h1,         res:32'h8000_0000, ovf:1'b1, zero:1'b0, err:1'b0};
    tbl[1]  = '{port:1'b0, op:ALU_SRA,  a:32'h8000_0000, b:32'h4,         res:32'hF800_0000, ovf:1'b0, zero:1'b0, err:1'b0};
    tbl[2]  = '{port:1'b1, op:ALU_SLTU, a:32'h1,         b:32'h2,         res:32'h1,         ovf:1'b0, zero:1'b0, err:1'b0};
    tbl[3]  = '{port:1'b0, op:ALU_SUB,  a:32'h5,         b:32'h5,         res:32'h0,         ovf:1'b0, zero:1'b1, err:1'b0};
    tbl[4]  = '{port:1'b1, op:5'h1F,    a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, res:32'h0,         ovf:1'b0, zero:1'b0, err:1'b1};
    tbl[5]  = '{port:1'b0, op:5'h0C,    a:32'h0,         b:32'h0,         res:32'h0,         ovf:1'b0, zero:1'b0, err:1'b1};
    tbl[6]  = '{port:1'b1, op:ALU_BGEU, a:32'h5,         b:32'h3,         res:32'h1,         ovf:1'b0, zero:1'b0, err:1'b0};
    tbl[7]  = '{port:1'b0, op:ALU_XOR,  a:32'h0000_F0F0, b:32'h0000_FF00, res:32'h0000_0FF0, ovf:1'b0, zero:1'b0, err:1'b0};
    tbl[8]  = '{port:1'b1, op:ALU_SLL,  a:32'h1,         b:32'd31,        res:32'h8000_0000, ovf:1'b0, zero:1'b0, err:1'b0};
    tbl[9]  = '{port:1'b0, op:ALU_SUB,  a:32'h8000_0000, b:32'h1,         res:32'h7FFF_FFFF, ovf:1'b1, zero:1'b0, err:1'b0};
    tbl[10] = '{port:1'b1, op:ALU_SLT,  a:32'hFFFF_FFFF, b:32'h1,         res:32'h1,         ovf:1'b0, zero:1'b0, err:1'b0};
    tbl[11] = '{port:1'b0, op:ALU_AND,  a:32'h0F0F_0F0F, b:32'hF0F0_F0F0, res:32'h0,         ovf:1'b0, zero:1'b1, err:1'b0};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    hold0 = 1'b0; hold1 = 1'b0; exec_pending = 1'b0;
    acc_cyc0 = 0; acc_cyc1 = 0; hs_cyc0 = 0; hs_cyc1 = 0;
    cur0 = tbl[0]; cur1 = tbl[2]; exec_v = tbl[0];

    // Reset state, including ready held low while valids are present
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_req0_ready", 32'(req0_ready), 32'(0));
    chk("rst_req1_ready", 32'(req1_ready), 32'(0));
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'(0));
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'(0));
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'(0));
    chk("rst_rsp_err", 32'(rsp_err), 32'(0));
    chk("rst_rsp_res", rsp_res, 32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Both ports requesting continuously: grants alternate starting with port 0
    v0 = '{port:1'b0, op:ALU_SUB,  a:32'h5, b:32'h5, res:32'h0, ovf:1'b0, zero:1'b1, err:1'b0};
    v1 = '{port:1'b1, op:ALU_SLTU, a:32'h1, b:32'h2, res:32'h1, ovf:1'b0, zero:1'b0, err:1'b0};
    hold0 = 1'b1; hold1 = 1'b1;
    present(v0); present(v1);
    n = 0;
    while (glog.size() < 4 && n < 40) begin tick(); n++; end
    req0_valid = 1'b0; req1_valid = 1'b0;
    hold0 = 1'b0; hold1 = 1'b0;
    if (glog.size() < 4) fail_now("tie_timeout");
    else for (int i = 0; i < 4; i++) chk("tie_grant_order", 32'(glog[i]), 32'(i % 2));
    drain(20);

    // Single-port vectors with fixed accept and response latency
    for (int i = 0; i < 12; i++) begin
      int start;
      start = cyc;
      present(tbl[i]);
      drain(20);
      if (tbl[i].port) begin
        chk("vec_accept_cycle", 32'(acc_cyc1 - start), 32'(1));
        chk("vec_rsp_latency",  32'(hs_cyc1 - acc_cyc1), 32'(2));
      end else begin
        chk("vec_accept_cycle", 32'(acc_cyc0 - start), 32'(1));
        chk("vec_rsp_latency",  32'(hs_cyc0 - acc_cyc0), 32'(2));
      end
    end

    // Response backpressure on port 0 blocks port 1 until the handshake
    rsp0_ready = 1'b0;
    present('{port:1'b0, op:ALU_ADD, a:32'h2, b:32'h3, res:32'h5, ovf:1'b0, zero:1'b0, err:1'b0});
    n = 0;
    while (!rsp0_valid && n < 10) begin tick(); n++; end
    if (!rsp0_valid) fail_now("bp_rsp_timeout");
    present('{port:1'b1, op:ALU_OR, a:32'hF0, b:32'h0F, res:32'hFF, ovf:1'b0, zero:1'b0, err:1'b0});
    glog.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp0_valid", 32'(rsp0_valid), 32'(1));
      chk("bp_rsp1_valid", 32'(rsp1_valid), 32'(0));
      chk("bp_rsp_res", rsp_res, 32'h5);
      chk("bp_rsp_flags", {29'h0, rsp_ovf, rsp_zero, rsp_err}, 32'h0);
      chk("bp_req1_ready", 32'(req1_ready), 32'(0));
    end
    rsp0_ready = 1'b1;
    drain(20);
    chk("bp_grant_count", 32'(glog.size()), 32'(1));
    if (glog.size() > 0) chk("bp_grant_port", 32'(glog[0]), 32'(1));
    chk("bp_accept_after_hs", 32'(acc_cyc1 - hs_cyc0), 32'(1));

    // Reset during EXEC discards the transaction and restores last_grant
    present('{port:1'b0, op:ALU_OR, a:32'h1, b:32'h2, res:32'h3, ovf:1'b0, zero:1'b0, err:1'b0});
    drain(20);
    glog.delete();
    present('{port:1'b0, op:ALU_ADD, a:32'h7FFF_FFFF, b:32'h1, res:32'h8000_0000, ovf:1'b1, zero:1'b0, err:1'b0});
    n = 0;
    while (glog.size() == 0 && n < 10) begin tick(); n++; end
    if (glog.size() == 0) fail_now("rst_mid_accept_timeout");
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_rsp0_valid", 32'(rsp0_valid), 32'(0));
    chk("rst_mid_rsp1_valid", 32'(rsp1_valid), 32'(0));
    chk("rst_mid_alu_a", alu_a, 32'h0);
    chk("rst_mid_alu_b", alu_b, 32'h0);
    pend_q.delete();
    exec_pending = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) tick();
    glog.delete();
    present('{port:1'b0, op:ALU_ADD, a:32'h10, b:32'h20, res:32'h30, ovf:1'b0, zero:1'b0, err:1'b0});
    present('{port:1'b1, op:ALU_SRL, a:32'h80, b:32'h4, res:32'h8, ovf:1'b0, zero:1'b0, err:1'b0});
    drain(30);
    chk("post_rst_grants", 32'(glog.size()), 32'(2));
    if (glog.size() > 0) chk("post_rst_first_tie", 32'(glog[0]), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
